// File: rtl/uv_sched_pkg.sv
// ---------------------------------------------------------------------------
// uv_sched_pkg
// Shared types and constants for the chroma intra mode-decision sequencer.
//   state_e         : sequencer FSM states
//   DEF_FIXED_COST  : default per-mode header cost, mode m in bits [16m+15:16m]
//   JOIN_*          : bit positions of the completion sources in join_done
//   clamp_lambda    : negative lambda is treated as zero
// ---------------------------------------------------------------------------
package uv_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StScore,
      StComp,
      StFinish
   } state_e;

   localparam int unsigned DEF_NUM_MODES = 4;

   localparam logic [16*DEF_NUM_MODES-1:0] DEF_FIXED_COST =
      {16'd642, 16'd439, 16'd984, 16'd302};

   localparam int unsigned JOIN_SSE   = 0;
   localparam int unsigned JOIN_DISTO = 1;
   localparam int unsigned JOIN_COST  = 2;

   function automatic logic [31:0] clamp_lambda(input logic [31:0] lambda);
      return lambda[31] ? 32'd0 : lambda;
   endfunction

endpackage

// File: rtl/uv_done_join.sv
// ---------------------------------------------------------------------------
// uv_done_join
// Sticky join of JOIN_N completion pulses plus a per-candidate watchdog.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : clear sticky bits and watchdog (one cycle, at candidate issue)
//   enable     : accept pulses and advance the watchdog (candidate waiting)
//   join_done  : completion pulses, one per source
//   all_done   : every source seen, including pulses arriving this cycle
//   timeout    : this enabled cycle brings the watchdog to TIMEOUT_CYC
// ---------------------------------------------------------------------------
module uv_done_join #(
   parameter int unsigned JOIN_N      = 3,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              enable,
   input  logic [JOIN_N-1:0] join_done,
   output logic              all_done,
   output logic              timeout
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [JOIN_N-1:0] sticky_q, sticky_d, sticky_now;
   logic [CNT_W-1:0]  wd_q, wd_d;

   always_comb begin
      sticky_now = sticky_q | (enable ? join_done : '0);
      sticky_d   = sticky_q;
      wd_d       = wd_q;
      if (clear) begin
         sticky_d = '0;
         wd_d     = '0;
      end else if (enable) begin
         sticky_d = sticky_now;
         if (wd_q != CNT_W'(TIMEOUT_CYC)) begin
            wd_d = wd_q + CNT_W'(1);
         end
      end
   end

   assign all_done = &sticky_now;
   assign timeout  = enable && (wd_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_q <= '0;
         wd_q     <= '0;
      end else begin
         sticky_q <= sticky_d;
         wd_q     <= wd_d;
      end
   end

endmodule

// File: rtl/uv_mode_sched.sv
// ---------------------------------------------------------------------------
// uv_mode_sched
// Walks the UV prediction modes, issues one reconstruct per mode, joins the
// SSE / distortion / cost completions, scores each candidate and keeps the
// best. Ends with done (and sde_start unless the watchdog fired).
//   clk, rst     : clock, asynchronous active-high reset
//   start, abort : run request (accepted in IDLE only), synchronous abort
//   lambda_uv    : signed lambda, negatives clamp to 0
//   fixed_cost   : per-mode header cost, 16 bits per mode
//   join_done    : completion pulses (SSE, distortion, cost)
//   sse, sum     : current candidate SSE and level cost
//   rec_start    : reconstruct start, pred_sel = mode under evaluation
//   cap_best     : strobe to latch the winning candidate's datapath state
//   best_mode, best_score : running winner
//   busy, done, sde_start, timeout_err : run status
// ---------------------------------------------------------------------------
module uv_mode_sched
   import uv_sched_pkg::*;
#(
   parameter int unsigned NUM_MODES   = 4,
   parameter int unsigned JOIN_N      = 3,
   parameter int unsigned SCORE_W     = 64,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   abort,
   input  logic [31:0]            lambda_uv,
   input  logic [16*NUM_MODES-1:0] fixed_cost,
   input  logic [JOIN_N-1:0]      join_done,
   input  logic [31:0]            sse,
   input  logic [31:0]            sum,
   output logic                   rec_start,
   output logic [1:0]             pred_sel,
   output logic                   cap_best,
   output logic [1:0]             best_mode,
   output logic [SCORE_W-1:0]     best_score,
   output logic                   busy,
   output logic                   done,
   output logic                   sde_start,
   output logic                   timeout_err
);

   localparam logic [1:0] LAST_MODE = 2'(NUM_MODES - 1);

   state_e               state_q, state_d;
   logic [1:0]           m_q, m_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [1:0]           best_mode_q, best_mode_d;
   logic [SCORE_W-1:0]   best_score_q, best_score_d;
   logic                 terr_q, terr_d;
   logic                 join_clear, join_en, all_done, wd_timeout;

   logic [15:0]          fixed_m;
   logic [31:0]          lambda_eff;
   logic [SCORE_W-1:0]   base, score_calc;

   uv_done_join #(
      .JOIN_N      (JOIN_N),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_join (
      .clk       (clk),
      .rst       (rst),
      .clear     (join_clear),
      .enable    (join_en),
      .join_done (join_done),
      .all_done  (all_done),
      .timeout   (wd_timeout)
   );

   // Score arithmetic is modulo 2^SCORE_W by construction.
   assign fixed_m    = fixed_cost[{m_q, 4'b0} +: 16];
   assign lambda_eff = clamp_lambda(lambda_uv);
   assign base       = SCORE_W'({sum, 10'b0}) + SCORE_W'(fixed_m);
   assign score_calc = base * SCORE_W'(lambda_eff) + (SCORE_W'(sse) << 8);

   always_comb begin
      state_d      = state_q;
      m_d          = m_q;
      score_d      = score_q;
      best_mode_d  = best_mode_q;
      best_score_d = best_score_q;
      terr_d       = terr_q;
      rec_start    = 1'b0;
      cap_best     = 1'b0;
      done         = 1'b0;
      sde_start    = 1'b0;
      join_clear   = 1'b0;
      join_en      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StIssue;
               m_d     = '0;
               terr_d  = 1'b0;
            end
         end
         StIssue: begin
            rec_start  = 1'b1;
            join_clear = 1'b1;
            state_d    = StWait;
         end
         StWait: begin
            join_en = 1'b1;
            if (all_done) begin
               state_d = StScore;
            end else if (wd_timeout) begin
               terr_d  = 1'b1;
               state_d = StFinish;
            end
         end
         StScore: begin
            score_d = score_calc;
            state_d = StComp;
         end
         StComp: begin
            // Strict compare: ties keep the earlier mode.
            if ((m_q == 2'd0) || (score_q < best_score_q)) begin
               cap_best     = 1'b1;
               best_mode_d  = m_q;
               best_score_d = score_q;
            end
            if (m_q == LAST_MODE) begin
               state_d = StFinish;
            end else begin
               m_d     = m_q + 2'd1;
               state_d = StIssue;
            end
         end
         StFinish: begin
            done      = 1'b1;
            sde_start = ~terr_q;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abort wins over everything in flight; winner registers hold.
      if (abort && (state_q != StIdle)) begin
         state_d      = StIdle;
         cap_best     = 1'b0;
         done         = 1'b0;
         sde_start    = 1'b0;
         best_mode_d  = best_mode_q;
         best_score_d = best_score_q;
         terr_d       = terr_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         m_q          <= '0;
         score_q      <= '0;
         best_mode_q  <= '0;
         best_score_q <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         m_q          <= m_d;
         score_q      <= score_d;
         best_mode_q  <= best_mode_d;
         best_score_q <= best_score_d;
         terr_q       <= terr_d;
      end
   end

   assign pred_sel    = ((state_q == StIssue) || (state_q == StWait) ||
                         (state_q == StScore) || (state_q == StComp)) ? m_q : 2'd0;
   assign busy        = (state_q != StIdle);
   assign best_mode   = best_mode_q;
   assign best_score  = best_score_q;
   assign timeout_err = terr_q;

endmodule

// File: doc/uv_mode_sched.md
Name: uv_mode_sched

Overview:
Sequencer for the chroma intra mode-decision datapath. It walks the candidate UV prediction modes in order and, for each mode, issues one start to the shared reconstruct engine. It then waits for the three downstream completions (SSE, distortion, rate cost) and computes the RD score. It keeps the best score, strobes the datapath to latch the winning levels and reconstruction, and on completion kicks the diffusion-error store.

Parameters:
NUM_MODES, 4, number of candidate modes, evaluated as indices 0..NUM_MODES-1
JOIN_N, 3, number of completion sources joined per candidate
SCORE_W, 64, score width; all score arithmetic is unsigned and truncated to SCORE_W
TIMEOUT_CYC, 4096, maximum WAIT cycles per candidate before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to run a decision; ignored while busy
abort  in  1  synchronous abort; returns to IDLE
lambda_uv  in  32  signed lambda; a negative value is treated as 0
fixed_cost  in  16*NUM_MODES  per-mode header cost; mode m occupies bits [16m+15:16m]
join_done  in  JOIN_N  completion pulses; bit0 SSE, bit1 distortion, bit2 cost
sse  in  32  SSE of the current candidate, valid while all join bits are sticky
sum  in  32  level cost of the current candidate, same validity as sse
rec_start  out  1  one-cycle start to the reconstruct engine
pred_sel  out  2  prediction mode driven to the reconstruct engine
cap_best  out  1  one-cycle strobe: datapath latches levels, out and nz
best_mode  out  2  winning mode
best_score  out  SCORE_W  winning score
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle completion pulse
sde_start  out  1  one-cycle pulse coincident with done
timeout_err  out  1  sticky; set on watchdog expiry, cleared by the next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; sticky join bits 0; the watchdog counter is 0. Reset mid-run drops everything at once, and no done is issued.
- States: IDLE, ISSUE, WAIT, SCORE, COMP, FINISH.
- IDLE: on start, go to ISSUE. The candidate index is set to 0, timeout_err is cleared and busy is set.
- ISSUE (1 cycle): rec_start=1. pred_sel is driven to the candidate index and held through COMP. Sticky join bits and the watchdog are cleared. Go to WAIT.
- WAIT: each join_done bit sets its sticky bit.
  - Simultaneous pulses count individually.
  - Repeated pulses from an already-sticky source have no effect.
  - Pulses in IDLE, ISSUE or FINISH are ignored.
  - All sticky bits set (including a bit that sets in the current cycle) -> SCORE.
  - Watchdog reaches TIMEOUT_CYC -> set timeout_err, go to FINISH with done but no sde_start; best_* hold their last values.
- SCORE (1 cycle): register score = (({sum,10'b0} + fixed_cost[m]) * lambda_eff) + (sse << 8), truncated to SCORE_W. lambda_eff = max(lambda_uv, 0).
- COMP (1 cycle): if the candidate is 0, or score < best_score (strict), then cap_best=1, best_mode<=m and best_score<=score. Ties keep the earlier mode. If m==NUM_MODES-1, go to FINISH; otherwise increment m and go to ISSUE.
- FINISH (1 cycle): done=1, sde_start=1 (unless timed out), busy falls next cycle. Go to IDLE.
- start asserted during FINISH is ignored; start is accepted in IDLE only.
- abort in any non-IDLE state: go to IDLE next cycle, no done, busy=0, no cap_best, best_* hold.
- Per-candidate latency from rec_start to cap_best is 3 + W cycles, where W is the number of WAIT cycles.
- With zero-latency joins (all bits arriving the cycle after rec_start), the total run is NUM_MODES*4+1 cycles from start to done.

Decomposition:
- Package uv_sched_pkg holds: the state enum, default fixed costs (302, 984, 439, 642 for modes 0..3), and join bit indices (SSE=0, DISTO=1, COST=2).
- One sub-module, uv_done_join: sticky join register plus watchdog, with inputs clear/enable/join_done and outputs all_done/timeout.
- Score arithmetic and the FSM stay in the top level.

Test Plan:
- Basic run: lambda=1, fixed costs default; for modes 0..3, sum=0 and sse = 1000, 500, 800, 900. Required: best_mode=1, best_score=984+128000=128984. cap_best fires for m=0 and m=1 only; done at cycle 17 with zero-latency joins.
- Out-of-order joins: cost arrives at +1, SSE at +5, and distortion twice at +2/+3. Required: SCORE is entered exactly at the cycle after +5, and the duplicate pulse is harmless.
- Simultaneous joins: all three bits arrive in the same cycle. Required: SCORE follows on the next cycle.
- Tie: equal scores for modes 0 and 2. Required: best_mode=0, and there is no cap_best for mode 2.
- Negative lambda: lambda=-5, sum=3, sse=10 for all modes. Required: score=2560 for every mode, best_mode=0.
- Timeout and abort:
  - Withhold distortion for 4096 cycles -> timeout_err=1 and done=1, with sde_start=0.
  - A separate run with abort in WAIT -> IDLE, and no done follows.
  - rst asserted mid-WAIT -> all outputs read 0 immediately.
